unidade_controle_mc: RTL and testbench

// Multicycle MIPS control FSM, parametrised successor of the fixed-latency control unit. Decodes opcode/funct and

---
 rtl/unidade_controle_mc.sv | 260 ++++++++++++++++++++++++++
 tb/tb_unidade_controle_mc.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_mc.sv
// rtl/unidade_controle_mc.sv - multicycle MIPS control FSM with memory wait states and traps
//
// Ports:
//   clk, reset (sync, active-low)         clock and reset
//   opcode, funct, alu_ovf                IR fields and ALU overflow flag
//   mem_wr, ir_wr, mdr_wr                 memory / IR / MDR strobes
//   pc_wr, pc_wr_cond, branch_ne, pc_src  PC update control
//   a_wr, b_wr, alu_out_wr                datapath register loads
//   reg_wr, reg_dst, mem_to_reg           register-file write control
//   alu_src_a, alu_src_b, alu_op, iord    ALU operand / op and address select
//   epc_wr, halted, state_out             trap capture, BREAK status, debug state
// Optional build macro: OVERFLOW_EXC_EN (signed overflow in add/sub/addi traps to EXC_OVF).
module unidade_controle_mc #(
    parameter int MEM_WAIT   = 1,
    parameter int STATE_W    = 6,
    parameter int EXC_VECTOR = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               alu_ovf,
    output logic               mem_wr,
    output logic               ir_wr,
    output logic               mdr_wr,
    output logic               pc_wr,
    output logic               pc_wr_cond,
    output logic               branch_ne,
    output logic [1:0]         pc_src,
    output logic               a_wr,
    output logic               b_wr,
    output logic               alu_out_wr,
    output logic               reg_wr,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_op,
    output logic               iord,
    output logic               epc_wr,
    output logic               halted,
    output logic [STATE_W-1:0] state_out
);
    typedef enum logic [4:0] {
        S_RESET     = 5'd0,
        S_FETCH     = 5'd1,
        S_FETCH_WAIT= 5'd2,
        S_IR_WRITE  = 5'd3,
        S_DECODE    = 5'd4,
        S_R_EXEC    = 5'd5,
        S_R_WB      = 5'd6,
        S_ADDI_EXEC = 5'd7,
        S_ADDI_WB   = 5'd8,
        S_BRANCH    = 5'd9,
        S_MEM_ADDR  = 5'd10,
        S_LW_READ   = 5'd11,
        S_LW_WAIT   = 5'd12,
        S_LW_WB     = 5'd13,
        S_SW_WRITE  = 5'd14,
        S_SW_WAIT   = 5'd15,
        S_LUI       = 5'd16,
        S_J         = 5'd17,
        S_JR        = 5'd18,
        S_JAL       = 5'd19,
        S_EXC_ILL   = 5'd20,
        S_EXC_OVF   = 5'd21,
        S_BREAK     = 5'd22
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT);
    localparam logic [1:0] EXC_SRC   = 2'(EXC_VECTOR);

    state_t     state;
    state_t     next_state;
    logic [3:0] wcnt;
    logic       r_ovf_trap;
    logic       i_ovf_trap;

`ifdef OVERFLOW_EXC_EN
    // Only add/sub are signed operations; and/xor/slt never trap.
    assign r_ovf_trap = alu_ovf && (funct == 6'h20 || funct == 6'h22);
    assign i_ovf_trap = alu_ovf;
`else
    logic unused_ovf;
    assign unused_ovf = alu_ovf;
    assign r_ovf_trap = 1'b0;
    assign i_ovf_trap = 1'b0;
`endif

    // State register and wait counter. The counter is loaded whenever a
    // memory-access state is entered, so the following wait state always
    // spans MEM_WAIT+1 cycles (exactly one when MEM_WAIT is 0).
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_RESET;
            wcnt  <= 4'd0;
        end else begin
            state <= next_state;
            if (next_state inside {S_FETCH, S_LW_READ, S_SW_WRITE}) begin
                wcnt <= WAIT_LOAD;
            end else if ((state inside {S_FETCH_WAIT, S_LW_WAIT, S_SW_WAIT}) && wcnt != 4'd0) begin
                wcnt <= wcnt - 4'd1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_RESET:      next_state = S_FETCH;
            S_FETCH:      next_state = S_FETCH_WAIT;
            S_FETCH_WAIT: next_state = (wcnt == 4'd0) ? S_IR_WRITE : S_FETCH_WAIT;
            S_IR_WRITE:   next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    6'h00: begin
                        case (funct)
                            6'h20, 6'h22, 6'h24, 6'h26, 6'h2A: next_state = S_R_EXEC;
                            6'h08:   next_state = S_JR;
                            6'h0D:   next_state = S_BREAK;
                            6'h00:   next_state = S_FETCH;
                            default: next_state = S_EXC_ILL;
                        endcase
                    end
                    6'h04, 6'h05: next_state = S_BRANCH;
                    6'h08:        next_state = S_ADDI_EXEC;
                    6'h23, 6'h2B: next_state = S_MEM_ADDR;
                    6'h0F:        next_state = S_LUI;
                    6'h02:        next_state = S_J;
                    6'h03:        next_state = S_JAL;
                    default:      next_state = S_EXC_ILL;
                endcase
            end
            S_R_EXEC:    next_state = r_ovf_trap ? S_EXC_OVF : S_R_WB;
            S_ADDI_EXEC: next_state = i_ovf_trap ? S_EXC_OVF : S_ADDI_WB;
            S_MEM_ADDR:  next_state = (opcode == 6'h23) ? S_LW_READ : S_SW_WRITE;
            S_LW_READ:   next_state = S_LW_WAIT;
            S_LW_WAIT:   next_state = (wcnt == 4'd0) ? S_LW_WB : S_LW_WAIT;
            S_SW_WRITE:  next_state = S_SW_WAIT;
            S_SW_WAIT:   next_state = (wcnt == 4'd0) ? S_FETCH : S_SW_WAIT;
            S_BREAK:     next_state = S_BREAK;
            S_R_WB, S_ADDI_WB, S_BRANCH, S_LW_WB, S_LUI, S_J, S_JR, S_JAL,
            S_EXC_ILL, S_EXC_OVF: next_state = S_FETCH;
            default:     next_state = S_RESET;
        endcase
    end

    always_comb begin
        mem_wr     = 1'b0;
        ir_wr      = 1'b0;
        mdr_wr     = 1'b0;
        pc_wr      = 1'b0;
        pc_wr_cond = 1'b0;
        branch_ne  = 1'b0;
        pc_src     = 2'd0;
        a_wr       = 1'b0;
        b_wr       = 1'b0;
        alu_out_wr = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 2'd0;
        mem_to_reg = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 3'd0;
        iord       = 1'b0;
        epc_wr     = 1'b0;
        halted     = 1'b0;
        case (state)
            S_IR_WRITE: begin
                ir_wr     = 1'b1;
                pc_wr     = 1'b1;
                alu_src_b = 2'd1;
                alu_op    = 3'd1;
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut while A/B load.
                a_wr       = 1'b1;
                b_wr       = 1'b1;
                alu_out_wr = 1'b1;
                alu_src_b  = 2'd3;
                alu_op     = 3'd1;
            end
            S_R_EXEC: begin
                alu_src_a  = 1'b1;
                alu_out_wr = 1'b1;
                case (funct)
                    6'h20:   alu_op = 3'd1;
                    6'h22:   alu_op = 3'd2;
                    6'h24:   alu_op = 3'd3;
                    6'h26:   alu_op = 3'd6;
                    6'h2A:   alu_op = 3'd7;
                    default: alu_op = 3'd0;
                endcase
            end
            S_R_WB: begin
                reg_wr  = 1'b1;
                reg_dst = 2'd1;
            end
            S_ADDI_EXEC, S_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd2;
                alu_op     = 3'd1;
                alu_out_wr = 1'b1;
            end
            S_ADDI_WB: reg_wr = 1'b1;
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 3'd2;
                pc_wr_cond = 1'b1;
                pc_src     = 2'd1;
                branch_ne  = opcode[0];
            end
            S_LW_READ: iord = 1'b1;
            S_LW_WAIT: begin
                // Address stays on ALUOut while MDR captures the read data.
                iord   = 1'b1;
                mdr_wr = 1'b1;
            end
            S_LW_WB: begin
                reg_wr     = 1'b1;
                mem_to_reg = 2'd1;
            end
            S_SW_WRITE, S_SW_WAIT: begin
                iord   = 1'b1;
                mem_wr = 1'b1;
            end
            S_LUI: begin
                reg_wr     = 1'b1;
                mem_to_reg = 2'd2;
            end
            S_J: begin
                pc_wr  = 1'b1;
                pc_src = 2'd3;
            end
            S_JR: begin
                pc_wr     = 1'b1;
                pc_src    = 2'd3;
                alu_src_a = 1'b1;
            end
            S_JAL: begin
                // PC already advanced in IR_WRITE, so $31 gets the return address.
                pc_wr      = 1'b1;
                pc_src     = 2'd3;
                reg_wr     = 1'b1;
                reg_dst    = 2'd2;
                mem_to_reg = 2'd3;
            end
            S_EXC_ILL, S_EXC_OVF: begin
                epc_wr = 1'b1;
                pc_wr  = 1'b1;
                pc_src = EXC_SRC;
            end
            S_BREAK: halted = 1'b1;
            default: ;
        endcase
    end

    assign state_out = STATE_W'(state);

endmodule

// File: tb/tb_unidade_controle_mc.sv
// tb/tb_unidade_controle_mc.sv - self-checking bench for unidade_controle_mc
`timescale 1ns/1ps
module tb_unidade_controle_mc;
    localparam int MW0 = 3;
    localparam int MW1 = 0;

    typedef struct packed {
        logic       mem_wr;
        logic       ir_wr;
        logic       mdr_wr;
        logic       pc_wr;
        logic       pc_wr_cond;
        logic       branch_ne;
        logic [1:0] pc_src;
        logic       a_wr;
        logic       b_wr;
        logic       alu_out_wr;
        logic       reg_wr;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       iord;
        logic       epc_wr;
        logic       halted;
    } outs_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] f;
        logic       ovf;
        outs_t      post;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b0, rst1 = 1'b0;
    logic [5:0] op0 = '0, f0 = '0, op1 = '0, f1 = '0;
    logic       ovf0 = 1'b0, ovf1 = 1'b0;
    outs_t      o0, o1;
    logic [5:0] st0, st1;

    int    checks = 0;
    int    errors = 0;
    outs_t exq[$];
    vec_t  vt[$];

    unidade_controle_mc #(.MEM_WAIT(MW0), .STATE_W(6), .EXC_VECTOR(2)) dut0 (
        .clk(clk), .reset(rst0), .opcode(op0), .funct(f0), .alu_ovf(ovf0),
        .mem_wr(o0.mem_wr), .ir_wr(o0.ir_wr), .mdr_wr(o0.mdr_wr), .pc_wr(o0.pc_wr),
        .pc_wr_cond(o0.pc_wr_cond), .branch_ne(o0.branch_ne), .pc_src(o0.pc_src),
        .a_wr(o0.a_wr), .b_wr(o0.b_wr), .alu_out_wr(o0.alu_out_wr), .reg_wr(o0.reg_wr),
        .reg_dst(o0.reg_dst), .mem_to_reg(o0.mem_to_reg), .alu_src_a(o0.alu_src_a),
        .alu_src_b(o0.alu_src_b), .alu_op(o0.alu_op), .iord(o0.iord), .epc_wr(o0.epc_wr),
        .halted(o0.halted), .state_out(st0)
    );

    unidade_controle_mc #(.MEM_WAIT(MW1), .STATE_W(6), .EXC_VECTOR(2)) dut1 (
        .clk(clk), .reset(rst1), .opcode(op1), .funct(f1), .alu_ovf(ovf1),
        .mem_wr(o1.mem_wr), .ir_wr(o1.ir_wr), .mdr_wr(o1.mdr_wr), .pc_wr(o1.pc_wr),
        .pc_wr_cond(o1.pc_wr_cond), .branch_ne(o1.branch_ne), .pc_src(o1.pc_src),
        .a_wr(o1.a_wr), .b_wr(o1.b_wr), .alu_out_wr(o1.alu_out_wr), .reg_wr(o1.reg_wr),
        .reg_dst(o1.reg_dst), .mem_to_reg(o1.mem_to_reg), .alu_src_a(o1.alu_src_a),
        .alu_src_b(o1.alu_src_b), .alu_op(o1.alu_op), .iord(o1.iord), .epc_wr(o1.epc_wr),
        .halted(o1.halted), .state_out(st1)
    );

    function automatic outs_t cur(input int d);
        return (d == 0) ? o0 : o1;
    endfunction

    function automatic logic [5:0] cur_st(input int d);
        return (d == 0) ? st0 : st1;
    endfunction

    task automatic chk(input string name, input int idx, input outs_t act, input outs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h required %h", name, idx, act, exp);
        end
    endtask

    task automatic set_in(input int d, input logic [5:0] op, input logic [5:0] f, input logic ovf);
        if (d == 0) begin op0 = op; f0 = f; ovf0 = ovf; end
        else begin op1 = op; f1 = f; ovf1 = ovf; end
    endtask

    task automatic set_rst(input int d, input logic v);
        if (d == 0) rst0 = v; else rst1 = v;
    endtask

    // Reference: the full per-cycle output trace of one instruction, starting
    // at its fetch cycle, built from the instruction's semantics.
    function automatic bit model(input logic [5:0] op, input logic [5:0] f, input logic ovf, input int mw);
        outs_t o, exc, mem_addr;
        logic [2:0] aop;
        bit trap_on;
`ifdef OVERFLOW_EXC_EN
        trap_on = ovf;
`else
        trap_on = 1'b0;
`endif
        exc = '0; exc.epc_wr = 1; exc.pc_wr = 1; exc.pc_src = 2'd2;
        mem_addr = '0; mem_addr.alu_src_a = 1; mem_addr.alu_src_b = 2'd2;
        mem_addr.alu_op = 3'd1; mem_addr.alu_out_wr = 1;
        o = '0;
        exq.push_back(o);
        for (int i = 0; i <= mw; i++) exq.push_back(o);
        o = '0; o.ir_wr = 1; o.pc_wr = 1; o.alu_src_b = 2'd1; o.alu_op = 3'd1;
        exq.push_back(o);
        o = '0; o.a_wr = 1; o.b_wr = 1; o.alu_out_wr = 1; o.alu_src_b = 2'd3; o.alu_op = 3'd1;
        exq.push_back(o);
        case (f)
            6'h20: aop = 3'd1;
            6'h22: aop = 3'd2;
            6'h24: aop = 3'd3;
            6'h26: aop = 3'd6;
            6'h2A: aop = 3'd7;
            default: aop = 3'd0;
        endcase
        o = '0;
        if (op == 6'h00) begin
            if (aop != 3'd0) begin
                o.alu_src_a = 1; o.alu_out_wr = 1; o.alu_op = aop;
                exq.push_back(o);
                if (trap_on && (f == 6'h20 || f == 6'h22)) exq.push_back(exc);
                else begin o = '0; o.reg_wr = 1; o.reg_dst = 2'd1; exq.push_back(o); end
            end else if (f == 6'h08) begin
                o.pc_wr = 1; o.pc_src = 2'd3; o.alu_src_a = 1; exq.push_back(o);
            end else if (f == 6'h0D) begin
                o.halted = 1;
                for (int i = 0; i < 10; i++) exq.push_back(o);
                return 1'b1;
            end else if (f != 6'h00) begin
                exq.push_back(exc);
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            o.alu_src_a = 1; o.alu_op = 3'd2; o.pc_wr_cond = 1; o.pc_src = 2'd1;
            o.branch_ne = (op == 6'h05);
            exq.push_back(o);
        end else if (op == 6'h08) begin
            exq.push_back(mem_addr);
            if (trap_on) exq.push_back(exc);
            else begin o.reg_wr = 1; exq.push_back(o); end
        end else if (op == 6'h23) begin
            exq.push_back(mem_addr);
            o.iord = 1; exq.push_back(o);
            o.mdr_wr = 1;
            for (int i = 0; i <= mw; i++) exq.push_back(o);
            o = '0; o.reg_wr = 1; o.mem_to_reg = 2'd1; exq.push_back(o);
        end else if (op == 6'h2B) begin
            exq.push_back(mem_addr);
            o.iord = 1; o.mem_wr = 1;
            for (int i = 0; i <= mw + 1; i++) exq.push_back(o);
        end else if (op == 6'h0F) begin
            o.reg_wr = 1; o.mem_to_reg = 2'd2; exq.push_back(o);
        end else if (op == 6'h02) begin
            o.pc_wr = 1; o.pc_src = 2'd3; exq.push_back(o);
        end else if (op == 6'h03) begin
            o.pc_wr = 1; o.pc_src = 2'd3; o.reg_wr = 1; o.reg_dst = 2'd2; o.mem_to_reg = 2'd3;
            exq.push_back(o);
        end else begin
            exq.push_back(exc);
        end
        return 1'b0;
    endfunction

    // Called at a negedge while the DUT sits in FETCH; returns at the next FETCH
    // (or, for BREAK, after ten halted cycles).
    task automatic run_instr(input int d, input string name, input logic [5:0] op, input logic [5:0] f,
                             input logic ovf, input bit has_post, input outs_t post, output bit brk);
        int  mw;
        bit  posted;
        mw = (d == 0) ? MW0 : MW1;
        posted = 1'b0;
        set_in(d, op, f, ovf);
        exq.delete();
        brk = model(op, f, ovf, mw);
        foreach (exq[i]) begin
            chk(name, i, cur(d), exq[i]);
            if (has_post && i == mw + 4) begin
                chk({name, "/post"}, i, cur(d), post);
                posted = 1'b1;
            end
            @(negedge clk);
        end
        if (has_post && !posted) chk({name, "/post"}, exq.size(), cur(d), post);
    endtask

    // Hold reset for n cycles checking the quiescent state, then release; ends in FETCH.
    task automatic do_reset(input int d, input int n);
        set_rst(d, 1'b0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("reset_outs", i, cur(d), '0);
            checks++;
            if (cur_st(d) !== 6'd0) begin
                errors++;
                $display("FAIL reset_state cycle %0d: got %0d required 0", i, cur_st(d));
            end
        end
        set_rst(d, 1'b1);
        @(negedge clk);
    endtask

    function automatic void add_v(input string name, input logic [5:0] op, input logic [5:0] f,
                                  input logic ovf, input outs_t post);
        vec_t v;
        v.name = name; v.op = op; v.f = f; v.ovf = ovf; v.post = post;
        vt.push_back(v);
    endfunction

    initial begin
        outs_t t, none;
        bit brk;
        logic [5:0] rop, rf;
        none = '0;

        t = '0; t.alu_src_a = 1; t.alu_out_wr = 1; t.alu_op = 3'd1; add_v("add", 6'h00, 6'h20, 1'b0, t);
        add_v("add_ovf", 6'h00, 6'h20, 1'b1, t);
        t.alu_op = 3'd2; add_v("sub", 6'h00, 6'h22, 1'b0, t);
        t.alu_op = 3'd3; add_v("and", 6'h00, 6'h24, 1'b1, t);
        t.alu_op = 3'd6; add_v("xor", 6'h00, 6'h26, 1'b0, t);
        t.alu_op = 3'd7; add_v("slt", 6'h00, 6'h2A, 1'b0, t);
        t = '0; t.pc_wr = 1; t.pc_src = 2'd3; t.alu_src_a = 1; add_v("jr", 6'h00, 6'h08, 1'b0, t);
        add_v("nop", 6'h00, 6'h00, 1'b0, none);
        t = '0; t.epc_wr = 1; t.pc_wr = 1; t.pc_src = 2'd2;
        add_v("ill_funct", 6'h00, 6'h3F, 1'b0, t);
        add_v("ill_op", 6'h3F, 6'h20, 1'b0, t);
        t = '0; t.alu_src_a = 1; t.alu_op = 3'd2; t.pc_wr_cond = 1; t.pc_src = 2'd1;
        add_v("beq", 6'h04, 6'h00, 1'b0, t);
        t.branch_ne = 1; add_v("bne", 6'h05, 6'h11, 1'b0, t);
        t = '0; t.alu_src_a = 1; t.alu_src_b = 2'd2; t.alu_op = 3'd1; t.alu_out_wr = 1;
        add_v("addi", 6'h08, 6'h00, 1'b0, t);
        add_v("addi_ovf", 6'h08, 6'h00, 1'b1, t);
        add_v("lw", 6'h23, 6'h00, 1'b0, t);
        add_v("sw", 6'h2B, 6'h00, 1'b0, t);
        t = '0; t.reg_wr = 1; t.mem_to_reg = 2'd2; add_v("lui", 6'h0F, 6'h00, 1'b0, t);
        t = '0; t.pc_wr = 1; t.pc_src = 2'd3; add_v("j", 6'h02, 6'h00, 1'b0, t);
        t.reg_wr = 1; t.reg_dst = 2'd2; t.mem_to_reg = 2'd3; add_v("jal", 6'h03, 6'h00, 1'b0, t);

        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            do_reset(d, 2);
            foreach (vt[i]) run_instr(d, vt[i].name, vt[i].op, vt[i].f, vt[i].ovf, 1'b1, vt[i].post, brk);

            // Reset asserted in the middle of a store wait.
            set_in(d, 6'h2B, 6'h00, 1'b0);
            repeat (((d == 0) ? MW0 : MW1) + 6) @(negedge clk);
            t = '0; t.iord = 1; t.mem_wr = 1;
            chk("sw_wait_before_reset", 0, cur(d), t);
            do_reset(d, 2);
            run_instr(d, "nop_after_reset", 6'h00, 6'h00, 1'b0, 1'b0, none, brk);

            for (int n = 0; n < 30; n++) begin
                if ($urandom_range(0, 9) < 6) begin
                    int k;
                    k = $urandom_range(0, vt.size() - 1);
                    rop = vt[k].op; rf = vt[k].f;
                end else begin
                    rop = 6'($urandom); rf = 6'($urandom);
                end
                if (rop == 6'h00 && rf == 6'h0D) rf = 6'h20;
                run_instr(d, "random", rop, rf, 1'($urandom), 1'b0, none, brk);
            end

            run_instr(d, "break", 6'h00, 6'h0D, 1'b0, 1'b0, none, brk);
            checks++;
            if (brk !== 1'b1) begin
                errors++;
                $display("FAIL break_model: got %0d required 1", brk);
            end
            do_reset(d, 2);
            run_instr(d, "add_after_break", 6'h00, 6'h20, 1'b0, 1'b0, none, brk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
